// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational 32-bit ALU between NREQ requesters.
// A round-robin arbiter grants at most one op per cycle. The granted op's
// operands are driven to the ALU. The ALU result is captured into a
// one-deep response slot owned by that requester.
// Optional feature: define ALU_ARB_PERF_EN to add the perf_ops/perf_stall
// counters. The arbitration behaviour does not change when it is defined.
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_ctrl,
    input  logic [NREQ*5-1:0]    req_shmt,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*32-1:0]   rsp_data,
    output logic [NREQ-1:0]      rsp_zero,
    output logic [NREQ*TAGW-1:0] rsp_tag,
    output logic [31:0]          alu_busa,
    output logic [31:0]          alu_busb,
    output logic [31:0]          alu_shift,
    output logic [3:0]           alu_ctrl,
    output logic [4:0]           alu_shmt,
    input  logic [31:0]          alu_busw,
    input  logic                 alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_stall
`endif
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    logic [NREQ-1:0] slot_state;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant_vec;
    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     cand;

    assign rsp_valid = slot_state;
    assign req_ready = grant_vec;

    // A requester can be served if its slot is free or is drained this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] & ((slot_state[i] == SLOT_EMPTY) | rsp_ready[i]);
        end
    end

    // Round-robin search. It starts at the pointer and wraps to 0. Reset blocks all grants.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!grant_any && !rst && eligible[cand[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_vec[i] = grant_any && (grant_idx == PW'(i));
        end
    end

    // Drive the ALU from the granted requester's slice. With no grant, drive zeros (AND of 0,0).
    always_comb begin
        alu_busa = '0;
        alu_busb = '0;
        alu_ctrl = '0;
        alu_shmt = '0;
        if (grant_any) begin
            alu_busa = req_a[32*grant_idx +: 32];
            alu_busb = req_b[32*grant_idx +: 32];
            alu_ctrl = req_ctrl[4*grant_idx +: 4];
            alu_shmt = req_shmt[5*grant_idx +: 5];
        end
        alu_shift = alu_busb >> alu_shmt;
    end

    // Advance the pointer past the winner, and capture the ALU result into the winner's slot.
    // A drained slot with no new grant returns to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_state <= {NREQ{SLOT_EMPTY}};
            rr_ptr     <= '0;
            rsp_data   <= '0;
            rsp_zero   <= '0;
            rsp_tag    <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (grant_vec[i]) begin
                    slot_state[i]             <= SLOT_FULL;
                    rsp_data[32*i +: 32]      <= alu_busw;
                    rsp_zero[i]               <= alu_zero;
                    rsp_tag[TAGW*i +: TAGW]   <= req_tag[TAGW*i +: TAGW];
                end else if (rsp_ready[i]) begin
                    slot_state[i] <= SLOT_EMPTY;
                end
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Saturating counters. One counts grants. The other counts cycles where a valid request was left waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (grant_any && perf_ops != 32'hFFFF_FFFF) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (|(req_valid & ~grant_vec) && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb.
// A behavioural ALU stands in for the shared ALU. A predictor models the
// round-robin policy and pushes expected responses into per-requester
// queues. A monitor compares the DUT outputs against those queues.
module tb_alu_share_arb;

    localparam int NREQ = 2;
    localparam int TAGW = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_ctrl;
    logic [NREQ*5-1:0]    req_shmt;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ*32-1:0]   rsp_data;
    logic [NREQ-1:0]      rsp_zero;
    logic [NREQ*TAGW-1:0] rsp_tag;
    logic [31:0]          alu_busa;
    logic [31:0]          alu_busb;
    logic [31:0]          alu_shift;
    logic [3:0]           alu_ctrl;
    logic [4:0]           alu_shmt;
    logic [31:0]          alu_busw;
    logic                 alu_zero;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]          perf_ops;
    logic [31:0]          perf_stall;
`endif

    typedef struct packed {
        logic [31:0]     data;
        logic            zero;
        logic [TAGW-1:0] tag;
    } rsp_t;

    rsp_t            exp_q [NREQ][$];
    logic [NREQ-1:0] model_full;
    int              model_rr;
    bit              checking_on;
    int              tests_run;
    int              tests_failed;

    alu_share_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .req_shmt  (req_shmt),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_tag   (rsp_tag),
        .alu_busa  (alu_busa),
        .alu_busb  (alu_busb),
        .alu_shift (alu_shift),
        .alu_ctrl  (alu_ctrl),
        .alu_shmt  (alu_shmt),
        .alu_busw  (alu_busw),
        .alu_zero  (alu_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the shared ALU. SRL consumes the precomputed shift bus.
    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_busw = alu_busa & alu_busb;
            4'd1:    alu_busw = alu_busa | alu_busb;
            4'd2:    alu_busw = alu_busa + alu_busb;
            4'd3:    alu_busw = alu_busb << alu_shmt;
            4'd4:    alu_busw = alu_shift;
            4'd6:    alu_busw = alu_busa - alu_busb;
            4'd7:    alu_busw = {31'd0, $signed(alu_busa) < $signed(alu_busb)};
            default: alu_busw = 32'd0;
        endcase
        alu_zero = (alu_busw == 32'd0);
    end

    // Reference result for one op, computed from its operands.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return b << s;
            4'd4:    return b >> s;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Predict the winner from the current inputs and the model state. Returns -1 for no grant.
    function automatic int predict_grant();
        int idx;
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (model_rr + k) % NREQ;
            if (req_valid[idx] && (!model_full[idx] || rsp_ready[idx])) return idx;
        end
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s, input logic [TAGW-1:0] t);
        req_ctrl[4*i +: 4]       = c;
        req_a[32*i +: 32]        = a;
        req_b[32*i +: 32]        = b;
        req_shmt[5*i +: 5]       = s;
        req_tag[TAGW*i +: TAGW]  = t;
    endtask

    // Present valid/ready for one cycle, then return 1 time unit after the edge.
    task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
        req_valid = v;
        rsp_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Predictor: on each edge, update the model slots and pointer, and queue the expected responses.
    always @(posedge clk) begin
        int   g;
        rsp_t e;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) exp_q[i].delete();
            model_full = '0;
            model_rr   = 0;
        end else begin
            g = predict_grant();
            for (int i = 0; i < NREQ; i++) begin
                if (g == i) begin
                    e.data = ref_alu(req_ctrl[4*i +: 4], req_a[32*i +: 32],
                                     req_b[32*i +: 32], req_shmt[5*i +: 5]);
                    e.zero = (e.data == 32'd0);
                    e.tag  = req_tag[TAGW*i +: TAGW];
                    exp_q[i].push_back(e);
                    model_full[i] = 1'b1;
                end else if (rsp_ready[i]) begin
                    model_full[i] = 1'b0;
                end
            end
            if (g >= 0) model_rr = (g + 1) % NREQ;
        end
    end

    // Monitor: mid-cycle check of the grant, the ALU drive and the response slots.
    // A response is popped once it is consumed.
    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] exp_ready;
        rsp_t            f;
        if (checking_on) begin
            g = predict_grant();
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check_output("req_ready", 32'(req_ready), 32'(exp_ready));
            if (g >= 0) begin
                check_output("alu_busa", alu_busa, req_a[32*g +: 32]);
                check_output("alu_busb", alu_busb, req_b[32*g +: 32]);
                check_output("alu_ctrl", 32'(alu_ctrl), 32'(req_ctrl[4*g +: 4]));
                check_output("alu_shift", alu_shift, req_b[32*g +: 32] >> req_shmt[5*g +: 5]);
            end else begin
                check_output("alu_idle_busa", alu_busa, 32'd0);
                check_output("alu_idle_ctrl", 32'(alu_ctrl), 32'd0);
            end
            if (!rst) begin
                for (int i = 0; i < NREQ; i++) begin
                    check_output($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]),
                                 32'(exp_q[i].size() != 0));
                    if (exp_q[i].size() != 0) begin
                        f = exp_q[i][0];
                        check_output($sformatf("rsp_data%0d", i), rsp_data[32*i +: 32], f.data);
                        check_output($sformatf("rsp_zero%0d", i), 32'(rsp_zero[i]), 32'(f.zero));
                        check_output($sformatf("rsp_tag%0d", i), 32'(rsp_tag[TAGW*i +: TAGW]),
                                     32'(f.tag));
                        if (rsp_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        checking_on  = 1'b0;
        rst          = 1'b1;
        req_valid    = '0;
        rsp_ready    = '0;
        req_a        = '0;
        req_b        = '0;
        req_ctrl     = '0;
        req_shmt     = '0;
        req_tag      = '0;
        @(posedge clk);
        #1;
        checking_on = 1'b1;
        apply_stimulus(2'b00, 2'b00);
        rst = 1'b0;

        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_data", rsp_data[31:0] | rsp_data[63:32], 32'd0);
        check_output("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        check_output("reset_rsp_tag", 32'(rsp_tag), 32'd0);

        // Single ADD from requester 0.
        set_req(0, 4'd2, 32'd5, 32'd7, 5'd0, 4'd3);
        apply_stimulus(2'b01, 2'b11);
        check_output("add_valid", 32'(rsp_valid[0]), 32'd1);
        check_output("add_data", rsp_data[31:0], 32'd12);
        check_output("add_zero", 32'(rsp_zero[0]), 32'd0);
        check_output("add_tag", 32'(rsp_tag[3:0]), 32'd3);

        // Both requesters busy with draining consumers: grants must alternate.
        for (int n = 0; n < 6; n++) begin
            set_req(0, 4'd2, $urandom, $urandom, 5'd0, 4'(n));
            set_req(1, 4'd1, $urandom, $urandom, 5'd0, 4'(n + 8));
            apply_stimulus(2'b11, 2'b11);
        end
        apply_stimulus(2'b00, 2'b11);

        // SRL through the precomputed shift bus.
        set_req(1, 4'd4, 32'd0, 32'h8000_0000, 5'd4, 4'd5);
        apply_stimulus(2'b10, 2'b11);
        check_output("srl_data", rsp_data[63:32], 32'h0800_0000);

        // Backpressure on slot 0 while requester 1 keeps being served.
        set_req(0, 4'd6, 32'd9, 32'd9, 5'd0, 4'd1);
        apply_stimulus(2'b01, 2'b10);
        for (int n = 0; n < 3; n++) begin
            set_req(1, 4'd2, 32'(n), 32'd1, 5'd0, 4'd2);
            apply_stimulus(2'b11, 2'b10);
        end
        check_output("bp_valid", 32'(rsp_valid[0]), 32'd1);
        check_output("bp_data", rsp_data[31:0], 32'd0);
        check_output("bp_zero", 32'(rsp_zero[0]), 32'd1);

        // Drain and refill slot 0 in the same cycle.
        set_req(0, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd6);
        apply_stimulus(2'b01, 2'b11);
        check_output("ovw_valid", 32'(rsp_valid[0]), 32'd1);
        check_output("ovw_data", rsp_data[31:0], 32'd1);
        check_output("ovw_tag", 32'(rsp_tag[3:0]), 32'd6);

        // Fill both slots, then reset: everything is dropped, and requester 0 wins first.
        set_req(1, 4'd2, 32'd3, 32'd4, 5'd0, 4'd9);
        apply_stimulus(2'b10, 2'b00);
        check_output("pre_rst_full", 32'(rsp_valid), 32'd3);
        rst = 1'b1;
        apply_stimulus(2'b11, 2'b11);
        rst = 1'b0;
        check_output("post_rst_valid", 32'(rsp_valid), 32'd0);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        check_output("post_rst_grant", 32'(req_ready), 32'd1);
        apply_stimulus(2'b11, 2'b11);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                        5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            end
            rst = ($urandom_range(0, 199) == 0);
            apply_stimulus(2'($urandom_range(0, 3)),
                           {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        end
        rst = 1'b0;
        apply_stimulus(2'b00, 2'b11);
        apply_stimulus(2'b00, 2'b11);
        checking_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
